// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: round-robin arbiter that shares one registered compare
// datapath (SLTU / SLT / EQ) between NUM_REQ requesters.
// Each transaction walks IDLE -> CMP -> RESP. The response is held until the
// requester accepts it.
// Optional feature macro: CMP_PERF_EN adds per-requester saturating grant
// counters on output perf_grants.
//
// Handshake semantics (both interfaces): a transfer happens on a rising clock
// edge where valid and ready are both 1. The requester side keeps req_valid
// and operands up until it sees req_ready. Operands are sampled only on the
// grant edge. On the response side, rsp_valid/rsp_id/rsp_result stay stable
// until the rsp_ready edge. rsp_ready is ignored outside RESP.
module cmp_share_arbiter #(
  parameter int WIDTH   = 64,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]     req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_result,
  output logic                     busy,
  output logic [1:0]               dbg_state
`ifdef CMP_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0]    perf_grants
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLTU = 2'b00;
  localparam logic [1:0] OP_SLT  = 2'b01;
  localparam logic [1:0] OP_EQ   = 2'b10;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic             rsp_result_q, rsp_result_d;

  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_fire;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [1:0]       sel_op;
  logic             cmp_res;

  // Round-robin search: first valid at or above the pointer, else wrap to the bottom.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!grant_found && req_valid[j] && (ID_W'(j) >= ptr_q)) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!grant_found && req_valid[j]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(j);
      end
    end
  end

  assign grant_fire = (state_q == ST_IDLE) && grant_found;

  // Operand mux for the winning requester, plus the one-hot ready (held low in reset).
  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_op    = '0;
    req_ready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_idx == ID_W'(j)) begin
        sel_a        = req_a[j*WIDTH +: WIDTH];
        sel_b        = req_b[j*WIDTH +: WIDTH];
        sel_op       = req_op[j*2 +: 2];
        req_ready[j] = grant_fire && rst_n;
      end
    end
  end

  // Compare on the latched operands; SLT falls back to unsigned when signs match.
  always_comb begin
    cmp_res = 1'b0;
    case (op_q)
      OP_SLTU: cmp_res = (a_q < b_q);
      OP_SLT:  cmp_res = (a_q[WIDTH-1] != b_q[WIDTH-1]) ? a_q[WIDTH-1] : (a_q < b_q);
      OP_EQ:   cmp_res = (a_q == b_q);
      default: cmp_res = 1'b0;
    endcase
  end

  // Next-state logic: grant and latch in IDLE, register the result in CMP, hold in RESP.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          state_d = ST_CMP;
          a_d     = sel_a;
          b_d     = sel_b;
          op_d    = sel_op;
          id_d    = grant_idx;
          ptr_d   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
      end
      ST_CMP: begin
        rsp_result_d = cmp_res;
        rsp_id_d     = id_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pointer, operand and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

`ifdef CMP_PERF_EN
  logic [15:0] perf_q [NUM_REQ];
  logic [15:0] perf_d [NUM_REQ];

  // Saturating grant counters, one per requester.
  always_comb begin
    for (int j = 0; j < NUM_REQ; j++) begin
      perf_d[j] = perf_q[j];
      if (grant_fire && (grant_idx == ID_W'(j)) && (perf_q[j] != 16'hFFFF))
        perf_d[j] = perf_q[j] + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_REQ; j++) perf_q[j] <= '0;
    end else begin
      for (int j = 0; j < NUM_REQ; j++) perf_q[j] <= perf_d[j];
    end
  end

  // Flatten the counters onto the output bus.
  always_comb begin
    perf_grants = '0;
    for (int j = 0; j < NUM_REQ; j++) perf_grants[j*16 +: 16] = perf_q[j];
  end
`endif

endmodule
